// File: rtl/serial_adder_sipo.sv
// Bit-serial adder with carry flip-flop and SIPO result register, LSB first.
// Optional OVERFLOW_FLAG_EN adds a two's-complement overflow output ovf.
module serial_adder_sipo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          state;
  logic            carry;
  logic [CntW-1:0] cnt;
  logic            s_bit;
  logic            c_next;

  assign s_bit  = a_bit ^ b_bit ^ carry;
  assign c_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state <= StAdd;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
          end
        end
        StAdd: begin
          sum   <= {s_bit, sum[WIDTH-1:1]};
          carry <= c_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= c_next;
`ifdef OVERFLOW_FLAG_EN
            // carry here is the carry into the MSB position
            ovf   <= carry ^ c_next;
`endif
          end
        end
        StDone: begin
          state <= StIdle;
          done  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_sipo.sv
// Directed self-checking bench for serial_adder_sipo (WIDTH=8).
module tb_serial_adder_sipo;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a_bit;
  logic       b_bit;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef OVERFLOW_FLAG_EN
  logic       ovf;
`endif

  int passed = 0;
  int total  = 0;

  serial_adder_sipo #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_bit (a_bit),
    .b_bit (b_bit),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef OVERFLOW_FLAG_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one addition: start sampled at edge 0, bit i consumed at edge i+1.
  // ign_at >= 1 re-asserts start so it is sampled at that ADD edge.
  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input int ign_at, output logic [7:0] s, output logic co,
                         output logic ov, output int busy_n, output logic early_done,
                         output logic done_w, output logic done_after);
    busy_n     = 0;
    early_done = 1'b0;
    ov         = 1'b0;
    start = 1'b1;
    cin   = c;
    step();
    start = 1'b0;
    cin   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) busy_n++;
      if (done !== 1'b0) early_done = 1'b1;
      a_bit = a[i];
      b_bit = b[i];
      start = (ign_at == i + 1);
      step();
    end
    start  = 1'b0;
    done_w = done;
    s      = sum;
    co     = cout;
`ifdef OVERFLOW_FLAG_EN
    ov     = ovf;
`endif
    if (busy === 1'b1) busy_n++;
    step();
    done_after = done;
    if (busy === 1'b1) busy_n++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    cin   = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({busy, done, sum, cout} !== 11'd0)
        $display("FAIL reset cycle %0d: busy=%b done=%b sum=%h cout=%b, want all 0",
                 i, busy, done, sum, cout);
      else passed++;
    end
    start = 1'b0;
    cin   = 1'b0;
    a_bit = 1'b0;
    b_bit = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input int ign_at, input logic [7:0] es,
                          input logic eco, input logic eov);
    logic [7:0] s;
    logic       co, ov, ed, dw, da;
    int         bn;
    run_add(a, b, c, ign_at, s, co, ov, bn, ed, dw, da);
    total++;
    if (s !== es) $display("FAIL %s sum: got %h, want %h", nm, s, es);
    else passed++;
    total++;
    if (co !== eco) $display("FAIL %s cout: got %b, want %b", nm, co, eco);
    else passed++;
    total++;
    if ({ed, dw, da} !== 3'b010)
      $display("FAIL %s done timing: early=%b at_edge8=%b after=%b, want 0 1 0",
               nm, ed, dw, da);
    else passed++;
    total++;
    if (bn != 8) $display("FAIL %s busy cycles: got %0d, want 8", nm, bn);
    else passed++;
`ifdef OVERFLOW_FLAG_EN
    total++;
    if (ov !== eov) $display("FAIL %s ovf: got %b, want %b", nm, ov, eov);
    else passed++;
`else
    if (ov !== 1'b0 && eov !== 1'b0) $display("FAIL %s ovf stub", nm);
`endif
  endtask

  task automatic test_basic();
    test_add("150+45", 8'b10010110, 8'b00101101, 1'b0, 0, 8'hC3, 1'b0, 1'b0);
    test_add("FF+00+1", 8'hFF, 8'h00, 1'b1, 0, 8'h00, 1'b1, 1'b0);
    test_add("7F+01", 8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    // start re-asserted at edge 3 is ignored; next add follows straight after
    test_add("ignored_start", 8'hFF, 8'h01, 1'b0, 3, 8'h00, 1'b1, 1'b0);
    test_add("b2b_no_stale", 8'h10, 8'h20, 1'b0, 0, 8'h30, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    logic saw_done;
    saw_done = 1'b0;
    start = 1'b1;
    cin   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_bit = 1'b1;
      b_bit = 1'b1;
      if (done !== 1'b0) saw_done = 1'b1;
      step();
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, sum, cout} !== 11'd0)
      $display("FAIL abort async: busy=%b done=%b sum=%h cout=%b, want all 0",
               busy, done, sum, cout);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) rst_n = 1'b1;
      if (done !== 1'b0) saw_done = 1'b1;
      step();
    end
    total++;
    if (saw_done !== 1'b0) $display("FAIL abort done: got pulse=%b, want 0", saw_done);
    else passed++;
    a_bit = 1'b0;
    b_bit = 1'b0;
    test_add("post_abort", 8'h01, 8'h01, 1'b0, 0, 8'h02, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_bit = 1'b0;
    b_bit = 1'b0;
    cin   = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
